// File: rtl/riscv_hwloop_pkg.sv
`default_nettype none
// ============================================================================
// riscv_hwloop_pkg
// Shared types and defaults for the hardware-loop jump controller.
// Revision: 1.0
// ============================================================================
package riscv_hwloop_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        JUMP_PEND = 1'b1
    } hwlp_jstate_e;

    localparam int N_HWLP_DEFAULT = 2;

    typedef logic [31:0] hwlp_cnt_t;

endpackage
`default_nettype wire

// File: rtl/riscv_hwloop_match.sv
`default_nettype none
// ============================================================================
// riscv_hwloop_match
// Combinational end-address match with innermost-first priority selection.
// Revision: 1.0
// ============================================================================
module riscv_hwloop_match
    import riscv_hwloop_pkg::*;
#(
    parameter int N_HWLP = N_HWLP_DEFAULT,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 1
) (
    input  logic [N_HWLP*ADDR_W-1:0] hwlp_end_addr_i,
    input  logic [N_HWLP*32-1:0]     hwlp_counter_i,
    input  logic [ADDR_W-1:0]        current_pc_i,
    input  logic                     pc_valid_i,
    output logic                     hit_o,
    output logic [IDX_W-1:0]         idx_o,
    output logic                     last_iter_o
);

    logic [N_HWLP-1:0] w_hit;

    generate
        for (genvar k = 0; k < N_HWLP; k++) begin : g_hit
            hwlp_cnt_t w_cnt;
            assign w_cnt    = hwlp_counter_i[k*32 +: 32];
            assign w_hit[k] = pc_valid_i
                              && (current_pc_i == hwlp_end_addr_i[k*ADDR_W +: ADDR_W])
                              && (w_cnt != '0);
        end
    endgenerate

    // Scan from the outermost down so the innermost hit is the one that sticks.
    always_comb begin
        hit_o       = |w_hit;
        idx_o       = '0;
        last_iter_o = 1'b0;
        for (int k = N_HWLP - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                idx_o       = IDX_W'(k);
                last_iter_o = (hwlp_counter_i[k*32 +: 32] == 32'd1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/riscv_hwloop_jump_ctrl.sv
`default_nettype none
// ============================================================================
// riscv_hwloop_jump_ctrl
// Issues loop-back jump requests and decrement strobes for hardware loops.
// Optional feature macro: HWLP_JUMP_CNT_EN (adds saturating jump_cnt_o).
// Revision: 1.0
// ============================================================================
module riscv_hwloop_jump_ctrl
    import riscv_hwloop_pkg::*;
#(
    parameter int N_HWLP = N_HWLP_DEFAULT,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_HWLP*ADDR_W-1:0] hwlp_start_addr_i,
    input  logic [N_HWLP*ADDR_W-1:0] hwlp_end_addr_i,
    input  logic [N_HWLP*32-1:0]     hwlp_counter_i,
    input  logic [ADDR_W-1:0]        current_pc_i,
    input  logic                     pc_valid_i,
    input  logic                     flush_i,
    output logic                     jump_req_o,
    output logic [ADDR_W-1:0]        jump_target_o,
    input  logic                     jump_ack_i,
    output logic [N_HWLP-1:0]        hwlp_dec_cnt_o,
`ifdef HWLP_JUMP_CNT_EN
    output logic [31:0]              jump_cnt_o,
`endif
    output logic                     busy_o
);

    localparam int IDX_W = (N_HWLP > 1) ? $clog2(N_HWLP) : 1;

    hwlp_jstate_e       r_state;
    logic               r_jump_req;
    logic [ADDR_W-1:0]  r_jump_target;
    logic [N_HWLP-1:0]  r_dec_cnt;

    logic               w_hit;
    logic [IDX_W-1:0]   w_idx;
    logic               w_last_iter;
    logic [ADDR_W-1:0]  w_start;

    riscv_hwloop_match #(
        .N_HWLP (N_HWLP),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_match (
        .hwlp_end_addr_i (hwlp_end_addr_i),
        .hwlp_counter_i  (hwlp_counter_i),
        .current_pc_i    (current_pc_i),
        .pc_valid_i      (pc_valid_i),
        .hit_o           (w_hit),
        .idx_o           (w_idx),
        .last_iter_o     (w_last_iter)
    );

    assign w_start = hwlp_start_addr_i[int'(w_idx)*ADDR_W +: ADDR_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_jump_req    <= 1'b0;
            r_jump_target <= '0;
            r_dec_cnt     <= '0;
        end else begin
            r_dec_cnt <= '0;
            case (r_state)
                IDLE: begin
                    if (w_hit && !flush_i) begin
                        r_dec_cnt <= N_HWLP'(1) << w_idx;
                        // Last iteration falls through: strobe only, no jump.
                        if (!w_last_iter) begin
                            r_state       <= JUMP_PEND;
                            r_jump_req    <= 1'b1;
                            r_jump_target <= w_start;
                        end
                    end
                end
                JUMP_PEND: begin
                    // Ack takes priority over flush; either way the request ends.
                    if (jump_ack_i || flush_i) begin
                        r_state    <= IDLE;
                        r_jump_req <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_jump_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef HWLP_JUMP_CNT_EN
    logic [31:0] r_jump_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_jump_cnt <= '0;
        end else if (r_jump_req && jump_ack_i && (r_jump_cnt != 32'hFFFF_FFFF)) begin
            r_jump_cnt <= r_jump_cnt + 32'd1;
        end
    end

    assign jump_cnt_o = r_jump_cnt;
`endif

    assign jump_req_o     = r_jump_req;
    assign jump_target_o  = r_jump_target;
    assign hwlp_dec_cnt_o = r_dec_cnt;
    assign busy_o         = (r_state == JUMP_PEND);

endmodule
`default_nettype wire
